// File: rtl/bus_irq_controller.sv
// -----------------------------------------------------------------------------
// bus_irq_controller
//   Merges up to NUM_SRC peripheral interrupt requests into the CPU's single
//   raise/ack interrupt pair. Each source has a pending latch, a mask bit and
//   an edge/level mode bit. The winner is chosen by fixed priority (index 0
//   highest) or round-robin. The winner's index is latched and can be read
//   over the 8-bit CPU bus.
//
//   Register map (offset from BASE_ADDR):
//     +0 PEND  read / write-1-to-clear
//     +1 MASK  read/write (1 = enabled)
//     +2 VEC   read only: bit7 = valid, [2:0] = latched vector
//     +3 MODE  read/write (1 = edge, 0 = level)
//
// Ports
//   CLK        system clock
//   RESET      synchronous, active-low reset
//   BUS_DATA   bidirectional data bus; driven only for one cycle after a read
//   BUS_ADDR   address bus
//   BUS_WE     write enable
//   SRC_IRQ    per-source interrupt requests, synchronous to CLK
//   IRQ_RAISE  interrupt request to the CPU
//   IRQ_ACK    one-cycle acknowledge pulse from the CPU
//   IRQ_VEC    index of the source currently being raised
// -----------------------------------------------------------------------------
module bus_irq_controller #(
  parameter int          NUM_SRC     = 8,
  parameter logic [7:0]  BASE_ADDR   = 8'hD0,
  parameter bit          RR_PRIORITY = 1'b0,
  parameter logic [7:0]  MODE_RESET  = 8'h00
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  output logic               IRQ_RAISE,
  input  logic               IRQ_ACK,
  output logic [2:0]         IRQ_VEC
);

  // Bits at or above NUM_SRC are held at zero in every per-source register.
  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_SRC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAISE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] prev_q;
  logic [2:0] vec_q, vec_d;
  logic       vld_q, vld_d;
  logic       raise_q, raise_d;
  logic [2:0] rr_q, rr_d;
  logic [1:0] state_q, state_d;
  logic       rd_en_q;
  logic [7:0] rd_data_q;

  logic [7:0] off;
  logic       hit, wr, rd;
  logic [7:0] wdata, rdata_mux;
  logic [7:0] src_ext, set_v, active;
  logic [2:0] start, win_idx;
  logic       win_found;
  logic [3:0] cand;
  logic       ack_ok;

  // Offset arithmetic wraps, so the 4-register window is a single compare.
  assign off   = BUS_ADDR - BASE_ADDR;
  assign hit   = (off < 8'd4);
  assign wr    = hit & BUS_WE;
  assign rd    = hit & ~BUS_WE;
  assign wdata = BUS_DATA & SRC_MASK;

  assign src_ext = 8'(SRC_IRQ) & SRC_MASK;
  // Edge-mode bits set on a rising edge, level-mode bits set while high.
  assign set_v   = (mode_q & src_ext & ~prev_q) | (~mode_q & src_ext);
  assign active  = pend_q & mask_q;

  // ACK only takes effect while the latched source is still unmasked;
  // otherwise the request stays raised and PEND is left alone.
  assign ack_ok  = (state_q == S_RAISE) && IRQ_ACK && mask_q[vec_q];

  always_comb begin
    rdata_mux = 8'h00;
    case (off[1:0])
      2'd0:    rdata_mux = pend_q;
      2'd1:    rdata_mux = mask_q;
      2'd2:    rdata_mux = {vld_q, 4'b0000, vec_q};
      default: rdata_mux = mode_q;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr && off[1:0] == 2'd1) mask_d = wdata;
    if (wr && off[1:0] == 2'd3) mode_d = wdata;

    // Order matters: W1C first, then a new set overrides it, then an
    // accepted ACK clears the serviced bit over any new set.
    pend_d = pend_q;
    if (wr && off[1:0] == 2'd0) pend_d = pend_d & ~wdata;
    pend_d = pend_d | set_v;
    if (ack_ok) pend_d[vec_q] = 1'b0;
  end

  // Winner search. Round-robin starts one past the last serviced index.
  always_comb begin
    start     = (rr_q == LAST_IDX) ? 3'd0 : rr_q + 3'd1;
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (RR_PRIORITY) begin
        cand = {1'b0, start} + 4'(k);
        if (cand >= 4'(NUM_SRC)) cand = cand - 4'(NUM_SRC);
      end else begin
        cand = 4'(k);
      end
      if (!win_found && active[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    vld_d   = vld_q;
    raise_d = raise_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          vec_d   = win_idx;
          vld_d   = 1'b1;
          raise_d = 1'b1;
          state_d = S_RAISE;
        end
      end
      S_RAISE: begin
        if (ack_ok) begin
          rr_d    = vec_q;
          raise_d = 1'b0;
          vld_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Forced deassert cycle between back-to-back interrupts.
        state_d = S_IDLE;
      end
      default: begin
        raise_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      mode_q  <= MODE_RESET & SRC_MASK;
      prev_q  <= 8'h00;
      vec_q   <= 3'd0;
      vld_q   <= 1'b0;
      raise_q <= 1'b0;
      rr_q    <= LAST_IDX;
      state_q <= S_IDLE;
      rd_en_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      prev_q  <= src_ext;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
      raise_q <= raise_d;
      rr_q    <= rr_d;
      state_q <= state_d;
      rd_en_q <= rd;
    end
  end

  // Read data is captured at the addressing edge and presented for one cycle.
  always_ff @(posedge CLK) begin
    if (rd) rd_data_q <= rdata_mux;
  end

  assign BUS_DATA  = rd_en_q ? rd_data_q : 8'hzz;
  assign IRQ_RAISE = raise_q;
  assign IRQ_VEC   = vec_q;

endmodule

// File: tb/tb_bus_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_bus_irq_controller
//   Two controllers share one bus with a pull-up, so a released bus reads 0xFF:
//     u_a : 8 sources, fixed priority, base 0xD0
//     u_b : 3 sources, round-robin,    base 0xE0
// -----------------------------------------------------------------------------
module tb_bus_irq_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic       we;
  logic [7:0] drv;
  logic       oe;
  wire  [7:0] bus;

  logic [7:0] src_a;
  logic       ack_a, raise_a;
  logic [2:0] vec_a;
  logic [2:0] src_b;
  logic       ack_b, raise_b;
  logic [2:0] vec_b;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] rd_v;
  logic [2:0] rr_exp [4];

  always #5 clk = ~clk;

  assign bus = oe ? drv : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (bus[g]);
  end

  bus_irq_controller #(
    .NUM_SRC(8), .BASE_ADDR(8'hD0), .RR_PRIORITY(1'b0), .MODE_RESET(8'h00)
  ) u_a (
    .CLK(clk), .RESET(rst_n), .BUS_DATA(bus), .BUS_ADDR(addr), .BUS_WE(we),
    .SRC_IRQ(src_a), .IRQ_RAISE(raise_a), .IRQ_ACK(ack_a), .IRQ_VEC(vec_a)
  );

  bus_irq_controller #(
    .NUM_SRC(3), .BASE_ADDR(8'hE0), .RR_PRIORITY(1'b1), .MODE_RESET(8'h00)
  ) u_b (
    .CLK(clk), .RESET(rst_n), .BUS_DATA(bus), .BUS_ADDR(addr), .BUS_WE(we),
    .SRC_IRQ(src_b), .IRQ_RAISE(raise_b), .IRQ_ACK(ack_b), .IRQ_VEC(vec_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; drv = d; oe = 1'b1; we = 1'b1;
    tick();
    we = 1'b0; oe = 1'b0; addr = 8'h00;
  endtask

  // Two cycles: addressing edge, then the cycle the DUT drives, then release.
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    addr = a; we = 1'b0;
    tick();
    d = bus;
    addr = 8'h00;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; addr = 8'h00; we = 1'b0; drv = 8'h00; oe = 1'b0;
    src_a = 8'h00; src_b = 3'b000; ack_a = 1'b0; ack_b = 1'b0;
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd2; rr_exp[3] = 3'd0;

    // ---- reset state
    tick(); tick();
    check("rst_raise_a", {7'd0, raise_a}, 8'h00);
    check("rst_vec_a",   {5'd0, vec_a},   8'h00);
    check("rst_bus",     bus,             8'hFF);
    rst_n = 1'b1;
    tick();
    bus_read(8'hD0, rd_v); check("rst_pend", rd_v, 8'h00);
    bus_read(8'hD1, rd_v); check("rst_mask", rd_v, 8'h00);
    bus_read(8'hD2, rd_v); check("rst_vecreg", rd_v, 8'h00);
    bus_read(8'hD3, rd_v); check("rst_mode", rd_v, 8'h00);

    // ---- single edge source, latency and vector readback
    bus_write(8'hD1, 8'hFF);
    bus_write(8'hD3, 8'hFF);
    src_a = 8'h08;
    tick();
    src_a = 8'h00;
    check("lat_n1_raise", {7'd0, raise_a}, 8'h00);
    tick();
    check("lat_n2_raise", {7'd0, raise_a}, 8'h01);
    check("t1_vec",       {5'd0, vec_a},   8'h03);
    bus_read(8'hD2, rd_v); check("t1_vecreg", rd_v, 8'h83);
    addr = 8'hD0;
    tick();
    check("rd_drive", bus, 8'h08);
    addr = 8'h00;
    tick();
    check("rd_release", bus, 8'hFF);
    check("t1_hold_raise", {7'd0, raise_a}, 8'h01);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    check("t1_ack_drop", {7'd0, raise_a}, 8'h00);
    tick();
    check("t1_gap_low", {7'd0, raise_a}, 8'h00);
    bus_read(8'hD0, rd_v); check("t1_pend_clr", rd_v, 8'h00);

    // ---- fixed priority between sources 2 and 5
    src_a = 8'h24;
    tick();
    src_a = 8'h00;
    tick();
    check("t2_raise1", {7'd0, raise_a}, 8'h01);
    check("t2_vec1",   {5'd0, vec_a},   8'h02);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    check("t2_gap", {7'd0, raise_a}, 8'h00);
    bus_read(8'hD0, rd_v); check("t2_pend_mid", rd_v, 8'h20);
    check("t2_raise2", {7'd0, raise_a}, 8'h01);
    check("t2_vec2",   {5'd0, vec_a},   8'h05);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    tick();
    bus_read(8'hD0, rd_v); check("t2_pend_end", rd_v, 8'h00);

    // ---- masking, ignored ACK in IDLE, set beats W1C
    bus_write(8'hD1, 8'h00);
    src_a = 8'h10;
    tick();
    src_a = 8'h00;
    tick(); tick();
    check("t4_masked_noraise", {7'd0, raise_a}, 8'h00);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    bus_read(8'hD0, rd_v); check("t4_pend_masked", rd_v, 8'h10);
    bus_write(8'hD1, 8'h10);
    check("t4_unmask_n0", {7'd0, raise_a}, 8'h00);
    tick();
    check("t4_unmask_raise", {7'd0, raise_a}, 8'h01);
    check("t4_vec",          {5'd0, vec_a},   8'h04);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    src_a = 8'h10;
    bus_write(8'hD0, 8'h10);
    src_a = 8'h00;
    bus_read(8'hD0, rd_v); check("t4_set_beats_w1c", rd_v, 8'h10);
    check("t4_reraise", {7'd0, raise_a}, 8'h01);
    check("t4_revec",   {5'd0, vec_a},   8'h04);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    tick();
    bus_write(8'hD1, 8'h00);
    src_a = 8'h40;
    tick();
    src_a = 8'h00;
    bus_read(8'hD0, rd_v); check("w1c_before", rd_v, 8'h40);
    bus_write(8'hD0, 8'h40);
    bus_read(8'hD0, rd_v); check("w1c_after", rd_v, 8'h00);

    // ---- reset during RAISE, with a read in flight
    bus_write(8'hD1, 8'hFF);
    src_a = 8'h02;
    tick();
    src_a = 8'h00;
    tick();
    check("t5_raise", {7'd0, raise_a}, 8'h01);
    check("t5_vec",   {5'd0, vec_a},   8'h01);
    addr = 8'hD0;
    rst_n = 1'b0;
    tick();
    check("t5_rst_raise", {7'd0, raise_a}, 8'h00);
    check("t5_rst_vec",   {5'd0, vec_a},   8'h00);
    check("t5_rst_bus",   bus,             8'hFF);
    addr = 8'h00;
    rst_n = 1'b1;
    tick();
    bus_read(8'hD0, rd_v); check("t5_pend", rd_v, 8'h00);
    bus_read(8'hD1, rd_v); check("t5_mask", rd_v, 8'h00);
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    check("t5_ack_noeffect", {7'd0, raise_a}, 8'h00);
    bus_read(8'hD2, rd_v); check("t5_vecreg", rd_v, 8'h00);

    // ---- round-robin across three level sources
    src_b = 3'b111;
    bus_write(8'hE1, 8'h07);
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 8 && !raise_b; c++) tick();
      check("rr_raise", {7'd0, raise_b}, 8'h01);
      check("rr_vec",   {5'd0, vec_b},   {5'd0, rr_exp[i]});
      ack_b = 1'b1;
      tick();
      ack_b = 1'b0;
      check("rr_drop", {7'd0, raise_b}, 8'h00);
    end
    src_b = 3'b000;
    bus_write(8'hE1, 8'h00);

    // ---- narrow instance readback and out-of-window addresses
    bus_write(8'hE1, 8'hFF);
    bus_read(8'hE1, rd_v); check("n3_mask", rd_v, 8'h07);
    bus_write(8'hE3, 8'hFF);
    bus_read(8'hE3, rd_v); check("n3_mode", rd_v, 8'h07);
    bus_read(8'hE4, rd_v); check("oor_e4", rd_v, 8'hFF);
    bus_read(8'hD4, rd_v); check("oor_d4", rd_v, 8'hFF);
    bus_read(8'hCF, rd_v); check("oor_cf", rd_v, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
